// File: rtl/uart_arb_pkg.sv
// Shared types and frame-length helper for the UART transmitter arbiter.
package uart_arb_pkg;

    typedef logic [1:0] parity_mode_t;

    localparam parity_mode_t PAR_NONE  = 2'b00;
    localparam parity_mode_t PAR_EVEN  = 2'b01;
    localparam parity_mode_t PAR_ODD   = 2'b10;
    localparam parity_mode_t PAR_NONE2 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        FRAME,
        GAP
    } arb_state_t;

    localparam int unsigned FRAME_BITS_NOPAR = 10;
    localparam int unsigned FRAME_BITS_PAR   = 11;

    // Serial bits per frame: start + 8 data + optional parity + stop.
    function automatic int unsigned frame_len(input parity_mode_t mode);
        return (mode == PAR_EVEN || mode == PAR_ODD) ? FRAME_BITS_PAR : FRAME_BITS_NOPAR;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr+1, or fixed lowest-index
// priority when UART_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

`ifdef UART_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        // Scan ptr+1 .. ptr+N_REQ so the last winner gets lowest priority.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters, pacing launches by frame length.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         REQ_VALID,
    input  logic [N_REQ*8-1:0]       REQ_DATA,
    input  logic [N_REQ*2-1:0]       REQ_PARITY,
    output logic [N_REQ-1:0]         REQ_READY,
    output logic                     TX_VALID,
    output logic [7:0]               TX_DATA,
    output logic [1:0]               TX_PARITY_MODE,
    output logic [$clog2(N_REQ)-1:0] GRANT_ID,
    output logic                     BUSY
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned CW   = $clog2(FRAME_BITS_PAR * BIT_CYCLES);
    localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    parity_mode_t    par_q, par_d;
    logic [ID_W-1:0] gid_q, gid_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  arb_ptr;
    logic             accept;
    logic [7:0]       sel_data;
    parity_mode_t     sel_par;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [ID_W-1:0] ptr_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            ptr_q <= gnt_id;
        end
    end

    assign arb_ptr = ptr_q;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req    (REQ_VALID),
        .ptr    (arb_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Ready is also gated by reset so nothing is accepted while RST_N is held low.
    assign REQ_READY = (state_q == IDLE && RST_N) ? gnt : '0;
    assign accept    = |REQ_READY;

    always_comb begin
        sel_data = '0;
        sel_par  = PAR_NONE;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = REQ_DATA[8*i +: 8];
                sel_par  = REQ_PARITY[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        par_d   = par_q;
        gid_d   = gid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = sel_data;
                    par_d   = sel_par;
                    gid_d   = gnt_id;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = CW'(frame_len(par_q) * BIT_CYCLES - 1);
                state_d = FRAME;
            end
            FRAME: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GW'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            par_q   <= PAR_NONE;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            par_q   <= par_d;
            gid_q   <= gid_d;
        end
    end

    assign TX_VALID       = (state_q == LAUNCH);
    assign BUSY           = (state_q != IDLE);
    assign TX_DATA        = data_q;
    assign TX_PARITY_MODE = par_q;
    assign GRANT_ID       = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: N_REQ=4, BIT_CYCLES=1, GAP_CYCLES=0
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [7:0]  req_par;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [1:0]  tx_par;
    logic [1:0]  grant_id;
    logic        busy;

    // Gap instance: GAP_CYCLES=3
    logic        g_rst_n;
    logic [3:0]  g_valid;
    logic [31:0] g_data;
    logic [7:0]  g_par;
    logic [3:0]  g_ready;
    logic        g_tx_valid;
    logic [7:0]  g_tx_data;
    logic [1:0]  g_tx_par;
    logic [1:0]  g_grant;
    logic        g_busy;

    uart_tx_arbiter #(
        .N_REQ      (4),
        .BIT_CYCLES (1),
        .GAP_CYCLES (0)
    ) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .REQ_VALID      (req_valid),
        .REQ_DATA       (req_data),
        .REQ_PARITY     (req_par),
        .REQ_READY      (req_ready),
        .TX_VALID       (tx_valid),
        .TX_DATA        (tx_data),
        .TX_PARITY_MODE (tx_par),
        .GRANT_ID       (grant_id),
        .BUSY           (busy)
    );

    uart_tx_arbiter #(
        .N_REQ      (4),
        .BIT_CYCLES (1),
        .GAP_CYCLES (3)
    ) dut_gap (
        .CLK            (clk),
        .RST_N          (g_rst_n),
        .REQ_VALID      (g_valid),
        .REQ_DATA       (g_data),
        .REQ_PARITY     (g_par),
        .REQ_READY      (g_ready),
        .TX_VALID       (g_tx_valid),
        .TX_DATA        (g_tx_data),
        .TX_PARITY_MODE (g_tx_par),
        .GRANT_ID       (g_grant),
        .BUSY           (g_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  par;
        logic [1:0]  gid;
        logic [7:0]  data;
        logic [1:0]  pmode;
        int unsigned len;
    } vec_t;

    vec_t vecs[6];

    localparam logic [31:0] DATA = 32'h4FC5F4A3;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int extra;
        int t;
        int sp;
        logic [1:0] rr_exp [5];

        vecs[0] = '{4'b0001, 8'h00, 2'd0, 8'hA3, 2'b00, 10};
        vecs[1] = '{4'b0010, 8'h04, 2'd1, 8'hF4, 2'b01, 11};
`ifdef UART_ARB_FIXED_PRIO_EN
        vecs[2] = '{4'b0110, 8'h2C, 2'd1, 8'hF4, 2'b11, 10};
        vecs[3] = '{4'b1011, 8'hC1, 2'd0, 8'hA3, 2'b01, 11};
        rr_exp  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        vecs[2] = '{4'b0110, 8'h2C, 2'd2, 8'hC5, 2'b10, 11};
        vecs[3] = '{4'b1011, 8'hC1, 2'd3, 8'h4F, 2'b11, 10};
        rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        vecs[4] = '{4'b1111, 8'h00, 2'd0, 8'hA3, 2'b00, 10};
        vecs[5] = '{4'b1100, 8'h60, 2'd2, 8'hC5, 2'b10, 11};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = DATA;
        req_par   = 8'h00;
        g_rst_n   = 1'b0;
        g_valid   = 4'h0;
        g_data    = 32'h0;
        g_par     = 8'h0;

        // Reset held with every requester pending
        repeat (4) begin
            @(negedge clk);
            check("reset_ready_valid_busy", {req_ready, tx_valid, busy}, 6'b0);
        end
        check("reset_regs", {tx_data, tx_par, grant_id}, 12'h000);

        @(negedge clk);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        g_rst_n   = 1'b1;

        // Table: one acceptance per record
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = vecs[i].valid;
            req_par   = vecs[i].par;
            #1;
            check("ready_onehot", req_ready, 32'h1 << vecs[i].gid);
            @(posedge clk);
            @(negedge clk);
            req_valid = 4'h0;
            check("launch_valid", tx_valid, 1);
            check("launch_data", tx_data, vecs[i].data);
            check("launch_parity", tx_par, vecs[i].pmode);
            check("launch_grant", grant_id, vecs[i].gid);
            nb    = 1;
            extra = 0;
            while (busy && nb < 40) begin
                @(negedge clk);
                if (busy) begin
                    nb++;
                    if (tx_valid) extra++;
                end
            end
            check("busy_len", nb, vecs[i].len + 1);
            check("tx_valid_once", extra, 0);
            repeat (3) @(negedge clk);
            check("idle_hold", {busy, tx_valid, tx_data, tx_par, grant_id},
                  {1'b0, 1'b0, vecs[i].data, vecs[i].pmode, vecs[i].gid});
        end

        // Single requester held: launch-to-launch spacing and sticky grant
        @(negedge clk);
        req_valid = 4'b0001;
        req_par   = 8'h00;
        t = 0;
        while (!tx_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("single_first_launch", tx_valid, 1);
        sp = 0;
        do begin
            @(negedge clk);
            sp++;
        end while (!tx_valid && sp < 40);
        check("single_spacing", sp, 12);
        check("single_data", tx_data, 8'hA3);
        check("single_grant", grant_id, 0);
        req_valid = 4'h0;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("single_drain", busy, 0);

        // All four pending continuously after reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_par   = 8'h00;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (!tx_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            check("rr_launch", tx_valid, 1);
            check("rr_grant", grant_id, rr_exp[k]);
            @(negedge clk);
        end
        req_valid = 4'h0;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end

        // Reset asserted mid-frame, then requester 3 served
        @(negedge clk);
        req_valid = 4'b0001;
        t = 0;
        while (!tx_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
        check("midframe_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_state", {busy, tx_valid, req_ready}, 6'b0);
        check("midframe_reset_regs", {tx_data, tx_par, grant_id}, 12'h000);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1000;
        #1;
        check("post_reset_ready", req_ready, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'h0;
        check("post_reset_launch", tx_valid, 1);
        check("post_reset_grant", grant_id, 3);
        check("post_reset_data", tx_data, 8'h4F);
        @(negedge clk);
        check("post_reset_pulse_end", tx_valid, 0);

        // Gap instance: requester 2 held, parity odd
        g_valid = 4'b0100;
        g_data  = 32'h004F0000;
        g_par   = 8'h20;
        t = 0;
        while (!g_tx_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("gap_first_launch", g_tx_valid, 1);
        sp = 0;
        do begin
            @(negedge clk);
            sp++;
        end while (!g_tx_valid && sp < 60);
        check("gap_spacing", sp, 16);
        check("gap_grant", g_grant, 2);
        check("gap_data", g_tx_data, 8'h4F);
        check("gap_parity", g_tx_par, 2'b10);
        g_valid = 4'h0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
